// File: rtl/obf_key_loader_if.sv
// obf_key_loader_if
//   Groups the key-loader request/serial/status signals into one bundle.
//   master : pin-logic side (drives start, key, ack_in; observes the rest)
//   slave  : the obf_key_loader itself
//   Signals:
//     start      request a transfer
//     key        key value to send (KEY_W bits)
//     ack_in     unlock acknowledge from the locked core
//     key_sclk   serial clock to the key receiver
//     key_sdata  serial data, MSB first
//     key_load   one-cycle strobe after the last frame bit
//     busy       transfer in progress
//     done       one-cycle pulse, acknowledge received
//     err        one-cycle pulse, acknowledge timed out
interface obf_key_loader_if #(
    parameter int KEY_W = 32
);
    logic             start;
    logic [KEY_W-1:0] key;
    logic             ack_in;
    logic             key_sclk;
    logic             key_sdata;
    logic             key_load;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, key, ack_in,
        input  key_sclk, key_sdata, key_load, busy, done, err
    );

    modport slave (
        input  start, key, ack_in,
        output key_sclk, key_sdata, key_load, busy, done, err
    );
endinterface

// File: rtl/obf_key_loader.sv
// obf_key_loader
//   Serializes {PREAMBLE, key, even parity} to the locked core's key
//   receiver over sclk/sdata, strobes key_load, then waits up to TIMEOUT
//   cycles for ack_in and reports done or err.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  obf_key_loader_if slave modport (start/key/ack_in in,
//          key_sclk/key_sdata/key_load/busy/done/err out)
//   All outputs are registered.
module obf_key_loader #(
    parameter int          KEY_W    = 32,
    parameter int          DIV      = 2,
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  PREAMBLE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    obf_key_loader_if.slave    bus
);
    localparam int N      = 8 + KEY_W + 1;
    localparam int PH_W   = $clog2(2 * DIV);
    localparam int BIT_W  = $clog2(N);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * DIV - 1);
    localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(DIV);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_WAIT_ACK,
        S_FINISH
    } state_t;

    state_t            r_state, w_state;
    logic [PH_W-1:0]   r_phase, w_phase;
    logic [BIT_W-1:0]  r_bit,   w_bit;
    logic [WAIT_W-1:0] r_wait,  w_wait;
    logic [N-1:0]      r_frame, w_frame;

    logic r_sclk, w_sclk;
    logic r_sdata, w_sdata;
    logic r_load, w_load;
    logic r_busy, w_busy;
    logic r_done, w_done;
    logic r_err,  w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_wait  <= '0;
            r_frame <= '0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_bit   <= w_bit;
            r_wait  <= w_wait;
            r_frame <= w_frame;
            r_sclk  <= w_sclk;
            r_sdata <= w_sdata;
            r_load  <= w_load;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_bit   = r_bit;
        w_wait  = r_wait;
        w_frame = r_frame;
        w_done  = 1'b0;
        w_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state = S_SHIFT;
                    w_phase = '0;
                    w_bit   = '0;
                    w_frame = {PREAMBLE, bus.key, ^bus.key};
                end
            end
            S_SHIFT: begin
                // The frame only shifts when a new bit's low phase begins,
                // so sdata is stable across the whole bit period.
                if (r_phase == PH_LAST) begin
                    w_phase = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state = S_LOAD;
                    end else begin
                        w_bit   = r_bit + BIT_W'(1);
                        w_frame = {r_frame[N-2:0], 1'b0};
                    end
                end else begin
                    w_phase = r_phase + PH_W'(1);
                end
            end
            S_LOAD: begin
                w_state = S_WAIT_ACK;
                w_wait  = '0;
            end
            S_WAIT_ACK: begin
                // Acknowledge wins over expiry on the final wait cycle.
                if (bus.ack_in) begin
                    w_state = S_FINISH;
                    w_done  = 1'b1;
                end else if (r_wait == WAIT_LAST) begin
                    w_state = S_FINISH;
                    w_err   = 1'b1;
                end else begin
                    w_wait = r_wait + WAIT_W'(1);
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in
        // step with the state they describe.
        w_sclk  = (w_state == S_SHIFT) && (w_phase >= PH_HIGH);
        w_sdata = (w_state == S_SHIFT) && w_frame[N-1];
        w_load  = (w_state == S_LOAD);
        w_busy  = (w_state == S_SHIFT) || (w_state == S_LOAD) ||
                  (w_state == S_WAIT_ACK);
    end

    assign bus.key_sclk  = r_sclk;
    assign bus.key_sdata = r_sdata;
    assign bus.key_load  = r_load;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_obf_key_loader.sv
module tb_obf_key_loader;
    localparam int         KEY_W    = 32;
    localparam int         DIV      = 2;
    localparam int         TIMEOUT  = 16;
    localparam int         N        = 8 + KEY_W + 1;
    localparam int         LOAD_OFF = 1 + 2 * DIV * N;
    localparam logic [7:0] PRE      = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    obf_key_loader_if #(.KEY_W(KEY_W)) bus ();

    obf_key_loader #(
        .KEY_W   (KEY_W),
        .DIV     (DIV),
        .TIMEOUT (TIMEOUT),
        .PREAMBLE(PRE)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected transfer: frame content, accept cycle and ack cycle index
    // within the wait window (1..TIMEOUT, 0 = never acknowledged).
    typedef struct {
        logic [N-1:0] frame;
        int           s;
        int           j;
    } exp_t;

    exp_t q[$];

    function automatic logic [N-1:0] model_frame(input logic [KEY_W-1:0] k);
        int ones = 0;
        for (int i = 0; i < KEY_W; i++) ones += int'(k[i]);
        return {PRE, k, (ones % 2 == 1)};
    endfunction

    function automatic int fin_of(input exp_t e);
        int load = e.s + LOAD_OFF;
        return (e.j != 0) ? load + e.j + 1 : load + TIMEOUT + 1;
    endfunction

    function automatic logic [5:0] outs();
        return {bus.key_sclk, bus.key_sdata, bus.key_load, bus.busy, bus.done, bus.err};
    endfunction

    // Receiver model + monitor
    logic [N-1:0] rx;
    int           rx_cnt      = 0;
    logic         prev_sclk   = 1'b0;
    bit           seen_load   = 1'b0;
    int           loads_total = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_cnt    = 0;
            rx        = '0;
            prev_sclk = 1'b0;
            seen_load = 1'b0;
        end else begin
            if (bus.key_sclk && !prev_sclk) begin
                if (q.size() == 0) chk("unexpected_sclk", bus.key_sclk, 0);
                else chk("sclk_rise_cycle", cyc, q[0].s + 1 + 2 * DIV * rx_cnt + DIV);
                rx = {rx[N-2:0], bus.key_sdata};
                rx_cnt++;
            end
            prev_sclk = bus.key_sclk;

            if (bus.key_load) begin
                loads_total++;
                if (q.size() == 0) begin
                    chk("unexpected_load", bus.key_load, 0);
                end else begin
                    chk("frame_content", rx, q[0].frame);
                    chk("frame_bits", rx_cnt, N);
                    chk("load_cycle", cyc, q[0].s + LOAD_OFF);
                    chk("load_busy_sclk_sdata", {bus.busy, bus.key_sclk, bus.key_sdata}, 3'b100);
                    seen_load = 1'b1;
                end
                rx_cnt = 0;
                rx     = '0;
            end

            if (bus.done || bus.err) begin
                if (q.size() == 0) begin
                    chk("unexpected_finish", {bus.done, bus.err}, 0);
                end else begin
                    chk("finish_cycle", cyc, fin_of(q[0]));
                    chk("done_err", {bus.done, bus.err}, (q[0].j != 0) ? 2'b10 : 2'b01);
                    chk("busy_at_finish", bus.busy, 0);
                    chk("load_before_finish", seen_load, 1);
                    void'(q.pop_front());
                    seen_load = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one transfer at the current cycle (DUT must be idle) and drives
    // it to one cycle past FINISH. smode: 0 start low while busy,
    // 1 random start pulses, 2 start held high (back-to-back).
    task automatic run_xfer(input logic [KEY_W-1:0] k, input int j,
                            input int smode, input bit do_rst);
        exp_t e;
        int   load;
        int   fin;
        bus.start  = 1'b1;
        bus.key    = k;
        bus.ack_in = 1'b0;
        e.frame = model_frame(k);
        e.s     = cyc;
        e.j     = j;
        q.push_back(e);
        load = e.s + LOAD_OFF;
        fin  = fin_of(e);
        forever begin
            @(posedge clk);
            #1;
            if (cyc == fin + 1) break;
            if (cyc == e.s + 1)
                chk("cycle1_busy_sdata_sclk", {bus.busy, bus.key_sdata, bus.key_sclk},
                    {1'b1, PRE[7], 1'b0});
            if (do_rst && cyc == e.s + 40) begin
                #1 rst = 1'b1;
                #1;
                chk("outputs_on_async_reset", outs(), 0);
                q.delete();
                bus.start  = 1'b0;
                bus.ack_in = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            bus.key = $urandom;
            case (smode)
                2:       bus.start = 1'b1;
                1:       bus.start = ($urandom_range(0, 3) == 0);
                default: bus.start = 1'b0;
            endcase
            if (j != 0 && cyc == load + j) bus.ack_in = 1'b1;
            else if (cyc <= load)          bus.ack_in = ($urandom_range(0, 2) == 0);
            else                           bus.ack_in = 1'b0;
        end
        bus.ack_in = 1'b0;
        bus.start  = (smode == 2);
    endtask

    initial begin
        int n_loads;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.key    = '0;
        bus.ack_in = 1'b0;
        idle(3);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        idle(2);

        // Directed: timeout, early ack, boundary ack, parity cases
        run_xfer(32'hDEADBEEF, 0, 0, 0);
        idle(3);
        run_xfer(32'h00000001, 3, 0, 0);
        idle(2);
        run_xfer(32'h00000000, TIMEOUT, 1, 0);
        idle(1);
        run_xfer(32'hFFFF0000, 1, 1, 0);
        idle(2);

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++)
            run_xfer($urandom, $urandom_range(0, TIMEOUT), 2, 0);
        run_xfer($urandom, $urandom_range(0, TIMEOUT), 0, 0);
        idle(2);

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            run_xfer($urandom, $urandom_range(0, TIMEOUT), $urandom_range(0, 1), 0);
            idle($urandom_range(0, 3));
        end

        // Reset mid-frame, then a quiet window with no key_load
        run_xfer($urandom, 5, 0, 1);
        n_loads = loads_total;
        idle(200);
        chk("no_load_after_reset", loads_total - n_loads, 0);
        chk("idle_after_reset", outs(), 0);

        // Recovery after reset
        run_xfer(32'h12345678, 8, 1, 0);
        idle(3);

        chk("all_transfers_completed", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
